dmac_top: RTL and testbench

DMAC_TOP -- requirements
Module: dmac_top

---
 rtl/dmac_top.sv | 206 ++++++++++++++++++++
 tb/tb_dmac_top.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_top.sv
// Two-channel AHB DMA master: fetches a 4-word descriptor per request, then copies
// beats one read/one write at a time with byte-lane realignment between src and dst.
module dmac_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MRData,
    input  logic        HReady,
    input  logic [1:0]  M_HResp,
    input  logic [1:0]  DmacReq,
    input  logic        Bus_Grant,
    output logic [31:0] MAddress,
    output logic [31:0] MWData,
    output logic [3:0]  MBurst_Size,
    output logic        MWrite,
    output logic [1:0]  MTrans,
    output logic [3:0]  MWStrb,
    output logic        Bus_Req,
    output logic        Interrupt,
    output logic [1:0]  ReqAck
);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_BUS, S_CFG, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  dmacreq_reg_q, dmacreq_reg_d;
    logic [31:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, data_q, data_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [1:0]  cfg_idx_q, cfg_idx_d;
    logic        cfg_dp_q, cfg_dp_d;
    logic [1:0]  req_ack_q, req_ack_d;

    logic [3:0]  hsize;
    logic [31:0] step, base, wdata_rot;
    logic [3:0]  wstrb;
    logic [4:0]  rot_bits;
    logic        err;

    assign hsize  = ctrl_q[7:4];
    assign err    = (M_HResp == 2'b01);
    assign base   = dmacreq_reg_q[1] ? 32'h1000_0000 : 32'h0000_0000;
    assign ReqAck = req_ack_q;

    always_comb begin
        step  = 32'd4;
        wstrb = 4'b1111;
        case (hsize)
            4'd0: begin
                step  = 32'd1;
                wstrb = 4'b0001 << dst_q[1:0];
            end
            4'd1: begin
                step  = 32'd2;
                wstrb = dst_q[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        // Rotate the captured word so the source byte lane lands on the destination lane.
        rot_bits  = {dst_q[1:0] - src_q[1:0], 3'b000};
        wdata_rot = (data_q << rot_bits) | (data_q >> (6'd32 - {1'b0, rot_bits}));
    end

    always_comb begin
        state_d       = state_q;
        dmacreq_reg_d = dmacreq_reg_q;
        src_d         = src_q;
        dst_d         = dst_q;
        cnt_d         = cnt_q;
        ctrl_d        = ctrl_q;
        data_d        = data_q;
        cfg_idx_d     = cfg_idx_q;
        cfg_dp_d      = cfg_dp_q;
        req_ack_d     = 2'b00;
        MAddress      = 32'h0;
        MWData        = 32'h0;
        MBurst_Size   = 4'h0;
        MWrite        = 1'b0;
        MTrans        = HT_IDLE;
        MWStrb        = 4'h0;
        Bus_Req       = 1'b0;
        Interrupt     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (DmacReq != 2'b00) begin
                    dmacreq_reg_d = DmacReq[0] ? 2'b01 : 2'b10;
                    req_ack_d     = DmacReq[0] ? 2'b01 : 2'b10;
                    state_d       = S_REQ_BUS;
                end
            end
            S_REQ_BUS: begin
                Bus_Req = 1'b1;
                if (Bus_Grant) begin
                    cfg_idx_d = 2'd0;
                    cfg_dp_d  = 1'b0;
                    state_d   = S_CFG;
                end
            end
            S_CFG: begin
                Bus_Req  = 1'b1;
                MAddress = base + 32'hA0 + {28'h0, cfg_idx_q, 2'b00};
                if (!cfg_dp_q) begin
                    MTrans = Bus_Grant ? HT_NONSEQ : HT_IDLE;
                    if (Bus_Grant && HReady) cfg_dp_d = 1'b1;
                end else if (err) begin
                    state_d = S_DONE;
                end else if (HReady) begin
                    cfg_dp_d  = 1'b0;
                    cfg_idx_d = cfg_idx_q + 2'd1;
                    case (cfg_idx_q)
                        2'd0: src_d = MRData;
                        2'd1: dst_d = MRData;
                        2'd2: cnt_d = MRData;
                        default: begin
                            ctrl_d = MRData[7:0];
                            // Disabled, reserved size or empty count: finish without data beats.
                            if (!MRData[16] || MRData[7:4] > 4'd2 || cnt_q == 32'h0)
                                state_d = S_DONE;
                            else
                                state_d = S_RD_ADDR;
                        end
                    endcase
                end
            end
            S_RD_ADDR: begin
                Bus_Req     = 1'b1;
                MBurst_Size = ctrl_q[3:0];
                MAddress    = src_q;
                MTrans      = Bus_Grant ? HT_NONSEQ : HT_IDLE;
                if (Bus_Grant && HReady) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                Bus_Req     = 1'b1;
                MBurst_Size = ctrl_q[3:0];
                MAddress    = src_q;
                if (err) begin
                    state_d = S_DONE;
                end else if (HReady) begin
                    data_d  = MRData;
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                Bus_Req     = 1'b1;
                MBurst_Size = ctrl_q[3:0];
                MAddress    = dst_q;
                MWrite      = 1'b1;
                MWStrb      = wstrb;
                MTrans      = Bus_Grant ? HT_NONSEQ : HT_IDLE;
                if (Bus_Grant && HReady) state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                Bus_Req     = 1'b1;
                MBurst_Size = ctrl_q[3:0];
                MAddress    = dst_q;
                MWrite      = 1'b1;
                MWStrb      = wstrb;
                MWData      = wdata_rot;
                if (err) begin
                    state_d = S_DONE;
                end else if (HReady) begin
                    src_d   = src_q + step;
                    dst_d   = dst_q + step;
                    cnt_d   = cnt_q - 32'd1;
                    state_d = (cnt_q == 32'd1) ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE: begin
                Interrupt = 1'b1;
                if ((DmacReq & dmacreq_reg_q) == 2'b00) begin
                    dmacreq_reg_d = 2'b00;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dmacreq_reg_q <= 2'b00;
            src_q         <= 32'h0;
            dst_q         <= 32'h0;
            cnt_q         <= 32'h0;
            ctrl_q        <= 8'h0;
            data_q        <= 32'h0;
            cfg_idx_q     <= 2'd0;
            cfg_dp_q      <= 1'b0;
            req_ack_q     <= 2'b00;
        end else begin
            state_q       <= state_d;
            dmacreq_reg_q <= dmacreq_reg_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            cnt_q         <= cnt_d;
            ctrl_q        <= ctrl_d;
            data_q        <= data_d;
            cfg_idx_q     <= cfg_idx_d;
            cfg_dp_q      <= cfg_dp_d;
            req_ack_q     <= req_ack_d;
        end
    end
endmodule

// File: tb/tb_dmac_top.sv
// Bench for dmac_top: two 256-byte AHB slave models (selected by addr[28]), a table of
// transfer descriptors with byte-level expected memory, plus grant-wait and reset sequences.
module tb_dmac_top;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] MRData;
    logic        HReady;
    logic [1:0]  M_HResp;
    logic [1:0]  DmacReq;
    logic        Bus_Grant;
    logic [31:0] MAddress, MWData;
    logic [3:0]  MBurst_Size, MWStrb;
    logic        MWrite, Bus_Req, Interrupt;
    logic [1:0]  MTrans, ReqAck;

    dmac_top dut (
        .clk(clk), .rst(rst), .MRData(MRData), .HReady(HReady), .M_HResp(M_HResp),
        .DmacReq(DmacReq), .Bus_Grant(Bus_Grant), .MAddress(MAddress), .MWData(MWData),
        .MBurst_Size(MBurst_Size), .MWrite(MWrite), .MTrans(MTrans), .MWStrb(MWStrb),
        .Bus_Req(Bus_Req), .Interrupt(Interrupt), .ReqAck(ReqAck)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       req;
        int               ch;
        logic [31:0]      src, dst, cnt, ctrl;
        bit               stall;
        int               err_beat;
        int               exp_wr;
        int               nstrb;
        logic [0:3][3:0]  strb;
    } vec_t;

    // slave memories and monitor state (written only by the slave process)
    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic        dp_valid, dp_write, dp_sel;
    logic [7:0]  dp_addr;
    int          wr_count, rd_beat, ack_cycles, nonseq_count, stab_viol;
    logic [3:0]  wstrb [8];
    logic [1:0]  ack_or;
    logic [95:0] prev_cur;
    logic        prev_chk;
    int          sc;

    // stimulus controls (written only by the main initial block)
    logic        fill_req;
    int          fill_seed, cfg_sel, err_beat;
    logic [31:0] cfg_w [4];
    bit          stall_en;

    logic [7:0]  e0 [256];
    logic [7:0]  e1 [256];
    int          n_vec, n_fail;
    vec_t        vt [9];

    function automatic logic [7:0] pat(int s, int k, int seed);
        return 8'(k * 13 + s * 101 + seed * 37 + 5);
    endfunction

    always @(negedge clk) begin
        if (stall_en) begin
            sc     <= (sc == 3) ? 0 : sc + 1;
            HReady <= (sc == 3);
        end else begin
            sc     <= 0;
            HReady <= 1'b1;
        end
    end

    always_comb begin
        MRData = '0;
        for (int k = 0; k < 4; k++)
            MRData[8*k +: 8] = dp_sel ? mem1[{dp_addr[7:2], 2'(k)}] : mem0[{dp_addr[7:2], 2'(k)}];
    end

    always_comb begin
        M_HResp = 2'b00;
        if (dp_valid === 1'b1 && !dp_write && dp_addr < 8'hA0 && rd_beat == err_beat)
            M_HResp = 2'b01;
    end

    always @(posedge clk) begin
        if (fill_req) begin
            for (int k = 0; k < 256; k++) begin
                mem0[8'(k)] <= pat(0, k, fill_seed);
                mem1[8'(k)] <= pat(1, k, fill_seed);
            end
            for (int w = 0; w < 4; w++)
                for (int b = 0; b < 4; b++)
                    if (cfg_sel == 0) mem0[8'(160 + 4*w + b)] <= cfg_w[w][8*b +: 8];
                    else              mem1[8'(160 + 4*w + b)] <= cfg_w[w][8*b +: 8];
            dp_valid     <= 1'b0;
            wr_count     <= 0;
            rd_beat      <= 0;
            ack_cycles   <= 0;
            ack_or       <= 2'b00;
            nonseq_count <= 0;
            prev_chk     <= 1'b0;
        end else begin
            if (HReady === 1'b1) begin
                if (dp_valid && dp_write) begin
                    for (int k = 0; k < 4; k++)
                        if (MWStrb[k]) begin
                            if (dp_sel) mem1[{dp_addr[7:2], 2'(k)}] <= MWData[8*k +: 8];
                            else        mem0[{dp_addr[7:2], 2'(k)}] <= MWData[8*k +: 8];
                        end
                    if (wr_count < 8) wstrb[wr_count] <= MWStrb;
                    wr_count <= wr_count + 1;
                end
                if (dp_valid && !dp_write && dp_addr < 8'hA0) rd_beat <= rd_beat + 1;
                dp_valid <= (MTrans == 2'b10);
                dp_write <= MWrite;
                dp_sel   <= MAddress[28];
                dp_addr  <= MAddress[7:0];
            end
            if (ReqAck != 2'b00) begin
                ack_or     <= ack_or | ReqAck;
                ack_cycles <= ack_cycles + 1;
            end
            if (MTrans == 2'b10) nonseq_count <= nonseq_count + 1;
            // a stalled phase must present identical outputs on the following cycle
            if (prev_chk && {MAddress, MWData, MWrite, MTrans, MWStrb, MBurst_Size, 17'h0} != prev_cur)
                stab_viol <= stab_viol + 1;
            prev_cur <= {MAddress, MWData, MWrite, MTrans, MWStrb, MBurst_Size, 17'h0};
            prev_chk <= (HReady === 1'b0) && (MTrans == 2'b10 || dp_valid === 1'b1);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v, input int seed);
        cfg_sel   = v.ch;
        cfg_w[0]  = v.src;
        cfg_w[1]  = v.dst;
        cfg_w[2]  = v.cnt;
        cfg_w[3]  = v.ctrl;
        fill_seed = seed;
        err_beat  = v.err_beat;
        fill_req  = 1'b1;
        @(negedge clk);
        fill_req  = 1'b0;
    endtask

    task automatic build_exp(input vec_t v, input int seed);
        int          sz;
        logic [31:0] s, d;
        logic [7:0]  val;
        for (int k = 0; k < 256; k++) begin
            e0[k] = pat(0, k, seed);
            e1[k] = pat(1, k, seed);
        end
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 4; b++)
                if (v.ch == 0) e0[160 + 4*w + b] = cfg_w[w][8*b +: 8];
                else           e1[160 + 4*w + b] = cfg_w[w][8*b +: 8];
        sz = (v.ctrl[7:4] == 4'd0) ? 1 : (v.ctrl[7:4] == 4'd1) ? 2 : 4;
        for (int i = 0; i < v.exp_wr; i++)
            for (int b = 0; b < sz; b++) begin
                s   = v.src + 32'(i * sz + b);
                d   = v.dst + 32'(i * sz + b);
                val = pat(int'(s[28]), int'(s[7:0]), seed);
                if (d[28]) e1[d[7:0]] = val;
                else       e0[d[7:0]] = val;
            end
    endtask

    task automatic chk_mem(input string name);
        int mism = 0;
        for (int k = 0; k < 256; k++) begin
            if (mem0[k] !== e0[k]) mism++;
            if (mem1[k] !== e1[k]) mism++;
        end
        chk(name, 64'(mism), 64'd0);
    endtask

    task automatic wait_irq();
        for (int c = 0; c < 5000 && Interrupt !== 1'b1; c++) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        load(v, idx);
        build_exp(v, idx);
        stall_en = v.stall;
        DmacReq  = v.req;
        wait_irq();
        chk($sformatf("v%0d_irq", idx), 64'(Interrupt), 64'd1);
        chk($sformatf("v%0d_busreq", idx), 64'(Bus_Req), 64'd0);
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_mtrans", idx), 64'(MTrans), 64'd0);
        chk($sformatf("v%0d_writes", idx), 64'(wr_count), 64'(v.exp_wr));
        chk($sformatf("v%0d_ack", idx), 64'(ack_or), (v.ch == 1) ? 64'd2 : 64'd1);
        chk($sformatf("v%0d_ackcyc", idx), 64'(ack_cycles), 64'd1);
        chk_mem($sformatf("v%0d_mem", idx));
        for (int i = 0; i < v.nstrb; i++)
            chk($sformatf("v%0d_strb%0d", idx, i), 64'(wstrb[i]), 64'(v.strb[i]));
        DmacReq = 2'b00;
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d_irq_clr", idx), 64'(Interrupt), 64'd0);
        stall_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int bad, w_snap, n_snap;
        n_vec = 0; n_fail = 0; stab_viol = 0;
        rst = 1'b1; DmacReq = 2'b00; Bus_Grant = 1'b1; stall_en = 1'b0;
        fill_req = 1'b0; fill_seed = 0; cfg_sel = 0; err_beat = -1;
        for (int w = 0; w < 4; w++) cfg_w[w] = 32'h0;

        //        req    ch src            dst            cnt  ctrl          stl err wr nst strobes
        vt[0] = '{2'b10, 1, 32'h1000_0004, 32'h0000_0000, 22, 32'h0001_0024, 0, -1, 22, 4, {4'hF, 4'hF, 4'hF, 4'hF}};
        vt[1] = '{2'b11, 0, 32'h0000_0004, 32'h1000_0000, 22, 32'h0001_0024, 1, -1, 22, 4, {4'hF, 4'hF, 4'hF, 4'hF}};
        vt[2] = '{2'b10, 1, 32'h1000_0001, 32'h0000_0001, 4,  32'h0001_0004, 0, -1, 4,  4, {4'h2, 4'h4, 4'h8, 4'h1}};
        vt[3] = '{2'b01, 0, 32'h0000_0010, 32'h1000_0040, 8,  32'h0001_0024, 0, 2,  2,  2, {4'hF, 4'hF, 4'h0, 4'h0}};
        vt[4] = '{2'b01, 0, 32'h0000_0000, 32'h1000_0000, 5,  32'h0000_0024, 0, -1, 0,  0, {4'h0, 4'h0, 4'h0, 4'h0}};
        vt[5] = '{2'b10, 1, 32'h1000_0000, 32'h0000_0000, 5,  32'h0001_0034, 0, -1, 0,  0, {4'h0, 4'h0, 4'h0, 4'h0}};
        vt[6] = '{2'b01, 0, 32'h0000_0000, 32'h1000_0000, 0,  32'h0001_0024, 0, -1, 0,  0, {4'h0, 4'h0, 4'h0, 4'h0}};
        vt[7] = '{2'b10, 1, 32'h1000_0002, 32'h0000_0010, 3,  32'h0001_0014, 0, -1, 3,  3, {4'h3, 4'hC, 4'h3, 4'h0}};
        vt[8] = '{2'b01, 0, 32'h0000_0023, 32'h1000_0062, 2,  32'h0001_0004, 1, -1, 2,  2, {4'h4, 4'h8, 4'h0, 4'h0}};

        repeat (3) @(negedge clk);
        chk("rst_maddr", 64'(MAddress), 64'd0);
        chk("rst_mwdata", 64'(MWData), 64'd0);
        chk("rst_ctl", 64'({MBurst_Size, MWrite, MTrans, MWStrb, Bus_Req, Interrupt, ReqAck}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // grant withheld for 20 cycles
        load(vt[0], 20);
        build_exp(vt[0], 20);
        Bus_Grant = 1'b0;
        DmacReq   = 2'b10;
        @(negedge clk);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (Bus_Req !== 1'b1 || MTrans !== 2'b00 || MAddress !== 32'h0 || MBurst_Size !== 4'h0) bad++;
        end
        chk("gnt_wait_outs", 64'(bad), 64'd0);
        chk("gnt_wait_nonseq", 64'(nonseq_count), 64'd0);
        Bus_Grant = 1'b1;
        wait_irq();
        chk("gnt_irq", 64'(Interrupt), 64'd1);
        @(negedge clk);
        chk("gnt_writes", 64'(wr_count), 64'd22);
        chk_mem("gnt_mem");
        DmacReq = 2'b00;
        repeat (2) @(negedge clk);

        // reset in the middle of a transfer
        load(vt[1], 21);
        DmacReq = 2'b01;
        for (int c = 0; c < 2000 && wr_count < 3; c++) @(negedge clk);
        chk("rmid_progress", 64'(wr_count >= 3), 64'd1);
        #2 rst = 1'b1;
        DmacReq = 2'b00;
        #1;
        chk("rmid_outs", 64'({Bus_Req, MTrans, MWrite, MWStrb, Interrupt}), 64'd0);
        chk("rmid_addr", 64'(MAddress), 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        w_snap = wr_count;
        n_snap = nonseq_count;
        repeat (40) @(negedge clk);
        chk("rmid_no_write", 64'(wr_count), 64'(w_snap));
        chk("rmid_no_trans", 64'(nonseq_count), 64'(n_snap));
        chk("rmid_busreq", 64'(Bus_Req), 64'd0);

        run_vec(vt[0], 30);
        chk("stall_stable", 64'(stab_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
